// File: rtl/reg_scoreboard_pkg.sv
// Shared constants, types and the source-hazard helper for the register scoreboard.
package reg_scoreboard_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned CNT_MAX  = 3;
    localparam int unsigned TOTAL_W  = 7;
    localparam int unsigned REG_W    = 5;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // A source is hazardous when it is read, is not $0 and still has pending writes.
    // A writeback retiring the last pending write this cycle clears the hazard
    // because the register file writes in the first half-cycle.
    function automatic logic src_hazard(
        input logic     uses,
        input reg_idx_t src,
        input cnt_t     pend_src,
        input logic     wb_valid,
        input reg_idx_t wb_rd
    );
        return uses && (src != '0) && (pend_src != '0) &&
               !(wb_valid && (wb_rd == src) && (pend_src == CNT_W'(1)));
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / status bundle between decode and the register scoreboard.
//   master: decode side (drives issue and writeback, observes stall and status)
//   slave : scoreboard side
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic                    IssueValid;
    reg_idx_t                IssueRs;
    reg_idx_t                IssueRt;
    logic                    IssueUsesRs;
    logic                    IssueUsesRt;
    reg_idx_t                IssueRd;
    logic                    IssueRegWrite;
    logic                    WbValid;
    reg_idx_t                WbRd;
    logic                    Stall;
    logic                    PCWrite;
    logic                    DecodeRegWrite;
    logic                    MuxControl;
    logic [NUM_REGS-1:0]     BusyMask;
    logic [TOTAL_W-1:0]      OutstandingTotal;
    logic                    ErrOverflow;
    logic                    ErrUnderflow;

    modport master (
        output IssueValid, IssueRs, IssueRt, IssueUsesRs, IssueUsesRt,
               IssueRd, IssueRegWrite, WbValid, WbRd,
        input  Stall, PCWrite, DecodeRegWrite, MuxControl,
               BusyMask, OutstandingTotal, ErrOverflow, ErrUnderflow
    );

    modport slave (
        input  IssueValid, IssueRs, IssueRt, IssueUsesRs, IssueUsesRt,
               IssueRd, IssueRegWrite, WbValid, WbRd,
        output Stall, PCWrite, DecodeRegWrite, MuxControl,
               BusyMask, OutstandingTotal, ErrOverflow, ErrUnderflow
    );

endinterface

// File: rtl/scoreboard_entry.sv
// One saturating pending-write counter for a single architectural register.
//   clk, rst_n : clock, async active-low reset
//   inc, dec   : accepted write / retired writeback this cycle
//   cnt        : registered pending count
//   ovf, unf   : this cycle's increment saturated / decrement hit zero
module scoreboard_entry
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output cnt_t cnt,
    output logic ovf,
    output logic unf
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    // Simultaneous inc and dec cancel, so neither limit can be violated.
    always_comb begin
        cnt_d = cnt_q;
        ovf   = 1'b0;
        unf   = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == CNT_W'(CNT_MAX)) ovf   = 1'b1;
            else                          cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            if (cnt_q == '0) unf   = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writes per register and stalls decode
// on RAW hazards.
//   Clk, Rst_n : clock, async active-low reset
//   sb         : issue/writeback inputs; Stall/PCWrite/DecodeRegWrite/MuxControl,
//                BusyMask, OutstandingTotal and sticky error flags out
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst_n,
    reg_scoreboard_if.slave  sb
);

    cnt_t                pend [NUM_REGS];
    logic [NUM_REGS-1:0] ovf_vec;
    logic [NUM_REGS-1:0] unf_vec;
    logic                haz_rs;
    logic                haz_rt;
    logic                stall;
    logic                accept;
    logic [NUM_REGS-1:0] busy;
    logic [TOTAL_W-1:0]  total;
    logic                err_ovf_q, err_ovf_d;
    logic                err_unf_q, err_unf_d;

    // $0 is never tracked.
    assign pend[0]    = '0;
    assign ovf_vec[0] = 1'b0;
    assign unf_vec[0] = 1'b0;

    for (genvar r = 1; r < int'(NUM_REGS); r++) begin : g_entry
        logic inc;
        logic dec;
        assign inc = accept && (sb.IssueRd == REG_W'(r));
        assign dec = sb.WbValid && (sb.WbRd == REG_W'(r));
        scoreboard_entry u_entry (
            .clk   (Clk),
            .rst_n (Rst_n),
            .inc   (inc),
            .dec   (dec),
            .cnt   (pend[r]),
            .ovf   (ovf_vec[r]),
            .unf   (unf_vec[r])
        );
    end

    // Hazard detection and accept decision.
    always_comb begin
        haz_rs = src_hazard(sb.IssueUsesRs, sb.IssueRs, pend[sb.IssueRs], sb.WbValid, sb.WbRd);
        haz_rt = src_hazard(sb.IssueUsesRt, sb.IssueRt, pend[sb.IssueRt], sb.WbValid, sb.WbRd);
        stall  = sb.IssueValid && (haz_rs || haz_rt);
        accept = sb.IssueValid && !stall && sb.IssueRegWrite && (sb.IssueRd != '0);
    end

    // Status derived from registered counts only.
    always_comb begin
        busy  = '0;
        total = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            busy[i] = (pend[i] != '0);
            total   = total + TOTAL_W'(pend[i]);
        end
    end

    // Sticky error flags.
    always_comb begin
        err_ovf_d = err_ovf_q | (|ovf_vec);
        err_unf_d = err_unf_q | (|unf_vec);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign sb.Stall            = stall;
    assign sb.PCWrite          = !stall;
    assign sb.DecodeRegWrite   = !stall;
    assign sb.MuxControl       = stall;
    assign sb.BusyMask         = busy;
    assign sb.OutstandingTotal = total;
    assign sb.ErrOverflow      = err_ovf_q;
    assign sb.ErrUnderflow     = err_unf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed per-cycle stimulus pushes the
// hand-computed expected status into a queue; a monitor pops and compares it
// one time unit after each falling edge.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    always #5 Clk = ~Clk;

    reg_scoreboard_if sb_if ();

    reg_scoreboard dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .sb    (sb_if.slave)
    );

    typedef struct {
        string       name;
        logic        stall;
        logic [31:0] busy;
        logic [6:0]  total;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0h required=%0h at %0t", name, field, act, req, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic [4:0] rd, input logic rw,
                         input logic wv, input logic [4:0] wrd);
        sb_if.IssueValid    = iv;
        sb_if.IssueRs       = rs;
        sb_if.IssueUsesRs   = urs;
        sb_if.IssueRt       = rt;
        sb_if.IssueUsesRt   = urt;
        sb_if.IssueRd       = rd;
        sb_if.IssueRegWrite = rw;
        sb_if.WbValid       = wv;
        sb_if.WbRd          = wrd;
    endtask

    // One cycle: wait for the falling edge, apply inputs, queue the expectation.
    task automatic step(input string name,
                        input logic iv, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic [4:0] rd, input logic rw,
                        input logic wv, input logic [4:0] wrd,
                        input logic e_stall, input logic [31:0] e_busy,
                        input logic [6:0] e_total, input logic e_ovf, input logic e_unf);
        exp_t e;
        @(negedge Clk);
        drive(iv, rs, urs, rt, urt, rd, rw, wv, wrd);
        e.name  = name;
        e.stall = e_stall;
        e.busy  = e_busy;
        e.total = e_total;
        e.ovf   = e_ovf;
        e.unf   = e_unf;
        exp_q.push_back(e);
    endtask

    // Monitor: compares the DUT against every queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "Stall",            32'(sb_if.Stall),            32'(e.stall));
                chk(e.name, "PCWrite",          32'(sb_if.PCWrite),          32'(!e.stall));
                chk(e.name, "DecodeRegWrite",   32'(sb_if.DecodeRegWrite),   32'(!e.stall));
                chk(e.name, "MuxControl",       32'(sb_if.MuxControl),       32'(e.stall));
                chk(e.name, "BusyMask",         sb_if.BusyMask,              e.busy);
                chk(e.name, "OutstandingTotal", 32'(sb_if.OutstandingTotal), 32'(e.total));
                chk(e.name, "ErrOverflow",      32'(sb_if.ErrOverflow),      32'(e.ovf));
                chk(e.name, "ErrUnderflow",     32'(sb_if.ErrUnderflow),     32'(e.unf));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        //    name        iv    rs    urs   rt    urt   rd     rw    wv    wrd     stall busy      tot  ovf   unf
        step("reset",     1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 32'h0,    7'd0, 1'b0, 1'b0);
        #3 Rst_n = 1'b1;
        // RAW on $8, cleared by same-cycle last writeback
        step("iss_rd8",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8,  1'b1, 1'b0, 5'd0,  1'b0, 32'h0,    7'd0, 1'b0, 1'b0);
        step("raw_rs8",   1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 32'h100,  7'd1, 1'b0, 1'b0);
        step("raw_wb8",   1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 32'h100,  7'd1, 1'b0, 1'b0);
        step("idle1",     1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 32'h0,    7'd0, 1'b0, 1'b0);
        // $0 ignored for issue, source and writeback
        step("iss_rd0",   1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 32'h0,    7'd0, 1'b0, 1'b0);
        step("src_r0",    1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0,  1'b0, 1'b1, 5'd0,  1'b0, 32'h0,    7'd0, 1'b0, 1'b0);
        // Same-cycle accept and writeback to $10 with pend=1
        step("iss_rd10",  1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 5'd0,  1'b0, 32'h0,    7'd0, 1'b0, 1'b0);
        step("acc_wb10",  1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 5'd10, 1'b0, 32'h400,  7'd1, 1'b0, 1'b0);
        step("wb10",      1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd10, 1'b0, 32'h400,  7'd1, 1'b0, 1'b0);
        // Saturation on $9
        step("rd9_a",     1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 32'h0,    7'd0, 1'b0, 1'b0);
        step("rd9_b",     1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 32'h200,  7'd1, 1'b0, 1'b0);
        step("rd9_c",     1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 32'h200,  7'd2, 1'b0, 1'b0);
        step("rd9_ovf",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 32'h200,  7'd3, 1'b0, 1'b0);
        step("ovf_seen",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 32'h200,  7'd3, 1'b1, 1'b0);
        // Rt hazard persists when writeback leaves pend above zero
        step("raw_rt9",   1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0,  1'b0, 1'b1, 5'd9,  1'b1, 32'h200,  7'd3, 1'b1, 1'b0);
        step("unused_rs", 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 5'd0,  1'b0, 32'h200,  7'd2, 1'b1, 1'b0);
        // Underflow on $11, then WAW on $12
        step("wb11_unf",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd11, 1'b0, 32'h1200, 7'd3, 1'b1, 1'b0);
        step("waw_rd12",  1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 5'd0,  1'b0, 32'h1200, 7'd3, 1'b1, 1'b1);
        step("iv0_noh",   1'b0, 5'd9, 1'b1, 5'd12,1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 32'h1200, 7'd4, 1'b1, 1'b1);
        // Build pend[8]=2 before the asynchronous reset pulse
        step("rd8_a",     1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8,  1'b1, 1'b0, 5'd0,  1'b0, 32'h1200, 7'd4, 1'b1, 1'b1);
        step("rd8_b",     1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8,  1'b1, 1'b0, 5'd0,  1'b0, 32'h1300, 7'd5, 1'b1, 1'b1);
        step("pend8_2",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 32'h1300, 7'd6, 1'b1, 1'b1);
        @(posedge Clk);
        #2 Rst_n = 1'b0;
        step("async_rst", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 32'h0,    7'd0, 1'b0, 1'b0);
        #3 Rst_n = 1'b1;
        // Writeback of a write discarded by reset underflows
        step("wb8_post",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 32'h0,    7'd0, 1'b0, 1'b0);
        step("unf_post",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 32'h0,    7'd0, 1'b0, 1'b1);
        @(negedge Clk);
        @(negedge Clk);
        #2;
        chk("queue", "drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
